count_wrap_monitor: RTL and testbench
=====================================

// Module: count_wrap_monitor
// PURPOSE
//  Watches the Q bus and enable of the upstream synchronous up counter, on the same clock.
//  Reports wrap-around (MAX->0) events and keeps a saturating wrap count.
//  Provides a one-shot armed match on a programmable count value, raising a sticky
//  interrupt until it is cleared. Sits directly downstream of the counter.
// PARAMETERS
//  WIDTH   4  width of the monitored count bus q
//  WCNT_W  8  width of the saturating wrap counter wrap_cnt
// PORTS
//  clk          in   1       rising-edge clock, shared with the counter
//  n_reset      in   1       asynchronous, active-low reset
//  enable       in   1       counter enable, as driven to the counter
//  q            in   WIDTH   counter output Q
//  match_val    in   WIDTH   count value to match; sampled every cycle
//  arm          in   1       pulse: arm the one-shot match (IDLE only)
//  irq_clr      in   1       pulse: clear irq, return to IDLE (FIRED only)
//  wrap_cnt_clr in   1       pulse: clear wrap_cnt
//  wrap_pulse   out  1       1-cycle pulse per detected wrap
//  match_pulse  out  1       1-cycle pulse when the armed match fires
//  irq          out  1       sticky; high while FSM is in FIRED
//  wrap_cnt     out  WCNT_W  number of wraps, saturating at all-ones
//  armed        out  1       high while FSM is in ARMED
// BEHAVIOUR
//  Reset (n_reset=0, takes effect immediately with no clock edge needed):
//   - q_prev=0, en_prev=0, prev_valid=0, FSM=IDLE.
//   - All outputs are 0.
//  Sample registers: each edge stores q_prev<=q, en_prev<=enable, prev_valid<=1.
//  Wrap detect:
//   - wrap = prev_valid & en_prev & (q_prev=={WIDTH{1'b1}}) & (q==0).
//   - wrap_pulse<=wrap: high for the one cycle after the first cycle that shows q==0.
//   - enable low while q was MAX (counter held, then reset) -> no wrap.
//   - Counter reset from MAX with enable high is reported as a wrap (accepted limitation).
//  wrap_cnt:
//   - wrap & wrap_cnt != all-ones -> +1; at all-ones it holds (no roll-over).
//   - wrap_cnt_clr alone -> 0; wrap_cnt_clr and wrap in the same cycle -> 1.
//  Match hit:
//   - hit = prev_valid & (q==match_val) & (q_prev!=q).
//   - Fires only on arrival at the value, never on a held value.
//  FSM (2-bit state), one transition per edge:
//   - IDLE:  arm -> ARMED; irq_clr ignored.
//   - ARMED: hit -> FIRED, with match_pulse<=1 for one cycle; arm and irq_clr ignored.
//   - FIRED: irq_clr -> IDLE; arm ignored, including arm+irq_clr together (result is IDLE).
//   - irq = (state==FIRED); armed = (state==ARMED); both registered, glitch-free.
//   - arm while q already equals match_val: no fire until q next arrives at match_val.
//   - Changing match_val while ARMED: takes effect from the next compare.
//   - Illegal state encoding -> IDLE on the next edge.
//  Latency: q change at edge k -> wrap_pulse/match_pulse/irq rise at edge k+1.
//  Async reset in any state -> IDLE at once; irq and armed drop without a clock.
// TESTING
//  1 n_reset=0 mid-run, clk stopped -> all outputs 0 immediately; FSM IDLE after release.
//  2 enable=1, q 0..15..0 -> wrap_pulse high 1 cycle, one edge after q==0; wrap_cnt=1;
//    16 clocks later wrap_cnt=2.
//  3 match_val=9, arm at q=3 -> armed=1; match_pulse 1 cycle one edge after q==9;
//    irq=1 held through later q==9; irq_clr -> irq=0, FSM IDLE.
//  4 enable=0 holding q=9, arm -> no fire; enable=1 -> fires when q next reaches 9
//    (16 counts later). Also q held at 15 with enable=0, then counter reset -> no wrap_pulse.
//  5 WCNT_W=2: 5 wraps -> wrap_cnt=3 (saturated); wrap_cnt_clr coincident with a wrap
//    -> wrap_cnt=1.
//  6 arm+irq_clr together in FIRED -> IDLE, armed=0; next arm -> ARMED.

Source files
------------

// File: rtl/count_wrap_monitor.sv
// Monitors an upstream up-counter: flags MAX->0 wraps, keeps a saturating wrap count,
// and provides a one-shot armed match on a programmable value with a sticky interrupt.
module count_wrap_monitor #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned WCNT_W = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              enable,
  input  logic [WIDTH-1:0]  q,
  input  logic [WIDTH-1:0]  match_val,
  input  logic              arm,
  input  logic              irq_clr,
  input  logic              wrap_cnt_clr,
  output logic              wrap_pulse,
  output logic              match_pulse,
  output logic              irq,
  output logic [WCNT_W-1:0] wrap_cnt,
  output logic              armed
);

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StArmed = 2'b01;
  localparam logic [1:0] StFired = 2'b10;

  localparam logic [WIDTH-1:0]  QMax   = {WIDTH{1'b1}};
  localparam logic [WCNT_W-1:0] CntMax = {WCNT_W{1'b1}};
  localparam logic [WCNT_W-1:0] CntOne = {{(WCNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]  q_prev_q;
  logic              en_prev_q;
  logic              prev_valid_q;
  logic [1:0]        state_q, state_d;
  logic              wrap_pulse_q;
  logic              match_pulse_q, match_pulse_d;
  logic [WCNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              irq_q, armed_q;

  logic wrap;
  logic hit;

  // A wrap needs the counter to have been enabled while sitting at MAX, so a held
  // counter that is then reset does not count.
  assign wrap = prev_valid_q & en_prev_q & (q_prev_q == QMax) & (q == '0);
  // Only arrival at the match value counts; a held value never re-fires.
  assign hit  = prev_valid_q & (q == match_val) & (q_prev_q != q);

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (wrap_cnt_clr) begin
      wrap_cnt_d = wrap ? CntOne : '0;
    end else if (wrap && (wrap_cnt_q != CntMax)) begin
      wrap_cnt_d = wrap_cnt_q + CntOne;
    end
  end

  always_comb begin
    state_d       = state_q;
    match_pulse_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (arm) state_d = StArmed;
      end
      StArmed: begin
        if (hit) begin
          state_d       = StFired;
          match_pulse_d = 1'b1;
        end
      end
      StFired: begin
        if (irq_clr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // irq/armed are registered from the next state so they never glitch on a state change.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      q_prev_q      <= '0;
      en_prev_q     <= 1'b0;
      prev_valid_q  <= 1'b0;
      state_q       <= StIdle;
      wrap_pulse_q  <= 1'b0;
      match_pulse_q <= 1'b0;
      wrap_cnt_q    <= '0;
      irq_q         <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      q_prev_q      <= q;
      en_prev_q     <= enable;
      prev_valid_q  <= 1'b1;
      state_q       <= state_d;
      wrap_pulse_q  <= wrap;
      match_pulse_q <= match_pulse_d;
      wrap_cnt_q    <= wrap_cnt_d;
      irq_q         <= (state_d == StFired);
      armed_q       <= (state_d == StArmed);
    end
  end

  assign wrap_pulse  = wrap_pulse_q;
  assign match_pulse = match_pulse_q;
  assign irq         = irq_q;
  assign wrap_cnt    = wrap_cnt_q;
  assign armed       = armed_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor: a default instance plus a WCNT_W=2 instance
// share all stimulus so saturation is seen within a few wraps.
module tb_count_wrap_monitor;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       n_reset;
  logic       enable;
  logic [3:0] q;
  logic [3:0] match_val;
  logic       arm, irq_clr, wrap_cnt_clr;

  logic       wrap_pulse, match_pulse, irq, armed;
  logic [7:0] wrap_cnt;
  logic       s_wrap_pulse, s_match_pulse, s_irq, s_armed;
  logic [1:0] s_wrap_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 if (clk_run) clk = ~clk;

  count_wrap_monitor #(.WIDTH(4), .WCNT_W(8)) u_dut (
    .clk(clk), .n_reset(n_reset), .enable(enable), .q(q), .match_val(match_val),
    .arm(arm), .irq_clr(irq_clr), .wrap_cnt_clr(wrap_cnt_clr),
    .wrap_pulse(wrap_pulse), .match_pulse(match_pulse), .irq(irq),
    .wrap_cnt(wrap_cnt), .armed(armed)
  );

  count_wrap_monitor #(.WIDTH(4), .WCNT_W(2)) u_dut_small (
    .clk(clk), .n_reset(n_reset), .enable(enable), .q(q), .match_val(match_val),
    .arm(arm), .irq_clr(irq_clr), .wrap_cnt_clr(wrap_cnt_clr),
    .wrap_pulse(s_wrap_pulse), .match_pulse(s_match_pulse), .irq(s_irq),
    .wrap_cnt(s_wrap_cnt), .armed(s_armed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance the modelled counter by one and clock it in.
  task automatic cnt_step();
    q = q + 4'd1;
    step();
  endtask

  initial begin
    n_reset = 1'b0; enable = 1'b0; q = '0; match_val = '0;
    arm = 1'b0; irq_clr = 1'b0; wrap_cnt_clr = 1'b0;
    step(); step();
    chk("rst_wrap_pulse", 32'(wrap_pulse), 32'd0);
    chk("rst_match_pulse", 32'(match_pulse), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);
    #2 n_reset = 1'b1;

    // Wrap detection: count 0..15..0 twice.
    enable = 1'b1; q = 4'd0;
    step();
    for (int i = 1; i <= 15; i++) cnt_step();
    chk("pre_wrap_pulse", 32'(wrap_pulse), 32'd0);
    cnt_step();  // q = 0
    chk("wrap1_pulse", 32'(wrap_pulse), 32'd1);
    chk("wrap1_cnt", 32'(wrap_cnt), 32'd1);
    cnt_step();
    chk("wrap1_pulse_drop", 32'(wrap_pulse), 32'd0);
    for (int i = 2; i <= 15; i++) cnt_step();
    cnt_step();  // q = 0
    chk("wrap2_pulse", 32'(wrap_pulse), 32'd1);
    chk("wrap2_cnt", 32'(wrap_cnt), 32'd2);
    chk("wrap2_small_cnt", 32'(s_wrap_cnt), 32'd2);

    // Armed match on 9, armed at q=3.
    match_val = 4'd9;
    cnt_step(); cnt_step();
    arm = 1'b1; cnt_step(); arm = 1'b0;  // q = 3
    chk("arm_armed", 32'(armed), 32'd1);
    chk("arm_irq", 32'(irq), 32'd0);
    for (int i = 4; i <= 8; i++) cnt_step();
    chk("arm_no_early_fire", 32'(match_pulse), 32'd0);
    cnt_step();  // q = 9
    chk("m1_pulse", 32'(match_pulse), 32'd1);
    chk("m1_irq", 32'(irq), 32'd1);
    chk("m1_armed", 32'(armed), 32'd0);
    cnt_step();
    chk("m1_pulse_drop", 32'(match_pulse), 32'd0);
    for (int i = 11; i <= 15; i++) cnt_step();
    cnt_step();  // q = 0, third wrap
    chk("wrap3_small_sat", 32'(s_wrap_cnt), 32'd3);
    for (int i = 1; i <= 9; i++) cnt_step();
    chk("m1_irq_sticky", 32'(irq), 32'd1);
    chk("m1_no_refire", 32'(match_pulse), 32'd0);
    irq_clr = 1'b1; cnt_step(); irq_clr = 1'b0;  // q = 10
    chk("clr_irq", 32'(irq), 32'd0);
    chk("clr_armed", 32'(armed), 32'd0);

    // Arm while held at the match value: fires only on the next arrival.
    for (int i = 11; i <= 15; i++) cnt_step();
    cnt_step();  // fourth wrap
    for (int i = 1; i <= 9; i++) cnt_step();
    enable = 1'b0;
    arm = 1'b1; step(); arm = 1'b0;
    step(); step();
    chk("held_armed", 32'(armed), 32'd1);
    chk("held_no_fire", 32'(match_pulse), 32'd0);
    chk("held_no_irq", 32'(irq), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 15; i++) cnt_step();  // 10..15, 0 (fifth wrap), 1..8
    chk("rearrive_not_yet", 32'(irq), 32'd0);
    chk("wrap5_cnt", 32'(wrap_cnt), 32'd5);
    chk("wrap5_small_sat", 32'(s_wrap_cnt), 32'd3);
    cnt_step();  // q = 9
    chk("rearrive_pulse", 32'(match_pulse), 32'd1);
    chk("rearrive_irq", 32'(irq), 32'd1);
    irq_clr = 1'b1; cnt_step(); irq_clr = 1'b0;

    // Counter held at MAX with enable low, then reset: not a wrap.
    for (int i = 11; i <= 15; i++) cnt_step();
    enable = 1'b0; step(); step();
    q = 4'd0; step();
    chk("held_max_no_wrap", 32'(wrap_pulse), 32'd0);
    chk("held_max_cnt", 32'(wrap_cnt), 32'd5);

    // wrap_cnt_clr coincident with a wrap, then alone.
    enable = 1'b1;
    for (int i = 1; i <= 15; i++) cnt_step();
    wrap_cnt_clr = 1'b1; cnt_step();  // q = 0
    chk("clr_wrap_pulse", 32'(wrap_pulse), 32'd1);
    chk("clr_wrap_cnt", 32'(wrap_cnt), 32'd1);
    chk("clr_wrap_small", 32'(s_wrap_cnt), 32'd1);
    cnt_step(); wrap_cnt_clr = 1'b0;  // q = 1
    chk("clr_alone_cnt", 32'(wrap_cnt), 32'd0);

    // arm + irq_clr together in FIRED ends in IDLE.
    match_val = 4'd3;
    arm = 1'b1; cnt_step(); arm = 1'b0;  // q = 2
    cnt_step();  // q = 3
    chk("f6_irq", 32'(irq), 32'd1);
    arm = 1'b1; irq_clr = 1'b1; cnt_step(); arm = 1'b0; irq_clr = 1'b0;
    chk("f6_both_irq", 32'(irq), 32'd0);
    chk("f6_both_armed", 32'(armed), 32'd0);
    arm = 1'b1; cnt_step(); arm = 1'b0;  // q = 5
    chk("f6_rearm", 32'(armed), 32'd1);

    // Async reset with the clock stopped while FIRED.
    match_val = 4'd6;
    cnt_step();  // q = 6
    chk("ar_irq_before", 32'(irq), 32'd1);
    chk("ar_pulse_before", 32'(match_pulse), 32'd1);
    clk_run = 1'b0;
    #3 n_reset = 1'b0;
    #1;
    chk("ar_irq", 32'(irq), 32'd0);
    chk("ar_match_pulse", 32'(match_pulse), 32'd0);
    chk("ar_armed", 32'(armed), 32'd0);
    chk("ar_wrap_pulse", 32'(wrap_pulse), 32'd0);
    #20 n_reset = 1'b1;
    #2 clk_run = 1'b1;
    step();
    chk("ar_idle_irq", 32'(irq), 32'd0);
    chk("ar_idle_armed", 32'(armed), 32'd0);
    arm = 1'b1; cnt_step(); arm = 1'b0;
    chk("ar_idle_arm", 32'(armed), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
